// File: rtl/softmax_normalize.sv
// Softmax normaliser: sums N_CLASS exp scores and looks up the reciprocal of the sum.
// It then streams out each score scaled by that reciprocal, in input order.
module softmax_normalize #(
    parameter int N_CLASS   = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 10,
    parameter int SUM_SHIFT = 8,
    parameter int IDX_MAX   = 511
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int SUM_W  = DATA_W + $clog2(N_CLASS);
    localparam int CNT_W  = $clog2(N_CLASS);
    localparam int IDX_W  = $clog2(IDX_MAX + 1);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CLASS - 1);

    typedef enum logic [1:0] {ACCUM, LOOKUP, NORM} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  sum_q;
    logic [DATA_W-1:0] inv_q;
    logic [DATA_W-1:0] scores_q [N_CLASS];
    logic              out_valid_q;
    logic              out_last_q;
    logic [DATA_W-1:0] out_data_q;

    // Entry k = round(4.0 / k) in Q.FRAC_W; entry 0 holds the zero-sum guard value.
    logic [DATA_W-1:0] recip [IDX_MAX+1];
    for (genvar k = 0; k <= IDX_MAX; k++) begin : g_recip
        localparam int unsigned DEN = (k == 0) ? 1 : k;
        localparam int unsigned VAL = (k == 0) ? 32'h7FFF
                                    : ((8 << FRAC_W) + DEN) / (2 * DEN);
        assign recip[k] = DATA_W'(VAL);
    end

    logic [SUM_W-1:0]  sum_shr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] inv_d;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] prob;

    assign sum_shr = sum_q >> SUM_SHIFT;
    assign idx     = (sum_shr > SUM_W'(IDX_MAX)) ? IDX_W'(IDX_MAX)
                                                 : sum_shr[IDX_W-1:0];
    assign inv_d   = (idx == '0) ? DATA_W'(16'h7FFF) : recip[idx];
    assign prod    = (PROD_W'(scores_q[cnt_q]) * PROD_W'(inv_q)) >> FRAC_W;
    assign prob    = (prod > PROD_W'({DATA_W{1'b1}})) ? '1 : prod[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            sum_q       <= '0;
            inv_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < N_CLASS; i++) scores_q[i] <= '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        scores_q[cnt_q] <= in_data;
                        sum_q           <= sum_q + SUM_W'(in_data);
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= LOOKUP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOOKUP: begin
                    inv_q   <= inv_d;
                    state_q <= NORM;
                end
                NORM: begin
                    if (out_valid_q && out_ready && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        cnt_q       <= '0;
                        sum_q       <= '0;
                        state_q     <= ACCUM;
                    end else if (!out_valid_q || out_ready) begin
                        // Refill the output register in the same cycle a beat drains.
                        out_data_q  <= prob;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (cnt_q == LAST);
                        if (cnt_q != LAST) cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_softmax_normalize.sv
// Self-checking bench for softmax_normalize.
// Expected probabilities come from a real-arithmetic reference model.
module tb_softmax_normalize;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    softmax_normalize dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    task automatic model(input logic [15:0] s [5], output logic [15:0] e [5]);
        longint sum = 0;
        longint idx;
        longint inv;
        longint p;
        for (int i = 0; i < 5; i++) sum += s[i];
        idx = sum / 256;
        if (idx > 511) idx = 511;
        if (idx == 0) inv = 32767;
        else inv = longint'($floor(4096.0 / real'(idx) + 0.5));
        for (int i = 0; i < 5; i++) begin
            p = (longint'(s[i]) * inv) / 1024;
            if (p > 65535) p = 65535;
            e[i] = 16'(p);
        end
    endtask

    // Sends the first n scores; returns at the negedge after the last accept.
    task automatic send(input logic [15:0] s [5], input int n, input bit gaps);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 200) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = s[i];
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        if (i < n) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: accepted %0d required %0d", i, n);
        end
    endtask

    // mode 0: always ready, 1: ready 1,0,0 pattern, 2: random ready
    task automatic collect(input logic [15:0] e [5], input int mode,
                           input bit chk_lat, input string tag);
        int beat = 0;
        int cyc = 0;
        int lat = -1;
        bit hold = 1'b0;
        logic [15:0] hd = '0;
        logic hl = 1'b0;
        while (beat < 5 && cyc < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s_in_ready_busy: got %b required 0", tag, in_ready);
            end
            if (out_valid === 1'b1) begin
                if (lat < 0) lat = cyc;
                if (hold) begin
                    n_cmp++;
                    if (out_data !== hd || out_last !== hl) begin
                        n_err++;
                        $display("FAIL %s_stall_stable: got %h/%b required %h/%b",
                                 tag, out_data, out_last, hd, hl);
                    end
                end
                if (out_ready) begin
                    n_cmp++;
                    if (out_data !== e[beat] || out_last !== (beat == 4)) begin
                        n_err++;
                        $display("FAIL %s_beat%0d: got %h last %b required %h last %b",
                                 tag, beat, out_data, out_last, e[beat], beat == 4);
                    end
                    beat++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hd = out_data;
                    hl = out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (beat < 5) begin
            n_err++;
            $display("FAIL %s_out_timeout: beats %0d required 5", tag, beat);
        end else if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_frame_end: in_ready %b out_valid %b required 1 0",
                     tag, in_ready, out_valid);
        end
        if (chk_lat) begin
            n_cmp++;
            if (lat != 2) begin
                n_err++;
                $display("FAIL %s_latency: got %0d required 2", tag, lat);
            end
        end
    endtask

    task automatic frame(input logic [15:0] s [5], input int mode,
                         input bit gaps, input bit chk_lat, input string tag);
        logic [15:0] e [5];
        model(s, e);
        send(s, 5, gaps);
        collect(e, mode, chk_lat, tag);
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_data !== 16'h0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy %b vld %b data %h last %b required 1 0 0000 0",
                     in_ready, out_valid, out_data, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_uniform();
        logic [15:0] s [5] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
        logic [15:0] e [5] = '{16'h00CD, 16'h00CD, 16'h00CD, 16'h00CD, 16'h00CD};
        send(s, 5, 1'b0);
        collect(e, 0, 1'b1, "uniform");
    endtask

    task automatic test_mixed();
        logic [15:0] s [5] = '{16'h0800, 16'h0400, 16'h0400, 16'h0000, 16'h0000};
        logic [15:0] e [5] = '{16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'h0000};
        send(s, 5, 1'b0);
        collect(e, 0, 1'b1, "mixed");
    endtask

    task automatic test_zero_sum();
        logic [15:0] s [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [15:0] e [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        send(s, 5, 1'b0);
        collect(e, 0, 1'b0, "zero_sum");
    endtask

    task automatic test_clamp();
        logic [15:0] s [5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic [15:0] e [5] = '{16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF};
        send(s, 5, 1'b0);
        collect(e, 0, 1'b0, "clamp");
    endtask

    task automatic test_backpressure();
        logic [15:0] s [5] = '{16'h0100, 16'h0900, 16'h0030, 16'h1000, 16'h0777};
        frame(s, 1, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_reset_midframe();
        logic [15:0] a [5] = '{16'h2000, 16'h3000, 16'h1000, 16'h0000, 16'h0000};
        logic [15:0] s [5] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
        logic [15:0] e [5] = '{16'h00CD, 16'h00CD, 16'h00CD, 16'h00CD, 16'h00CD};
        send(a, 3, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: rdy %b vld %b required 1 0", in_ready, out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send(s, 5, 1'b0);
        collect(e, 0, 1'b1, "midreset");
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_extra: out_valid %b required 0", out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] s [5];
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 2))
                    0:       s[i] = 16'($urandom_range(0, 255));
                    1:       s[i] = 16'($urandom_range(0, 16'h1000));
                    default: s[i] = 16'($urandom);
                endcase
            end
            frame(s, 2, 1'b1, 1'b0, $sformatf("random%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_mixed();
        test_zero_sum();
        test_clamp();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
